// File: rtl/srdl_counter_array.sv
// Array of NUM_CH saturating/wrapping event counters behind a narrow software register window.
// Optional macro SRDL_CNT_SNAPSHOT_EN adds a word-0-triggered snapshot for coherent multi-word reads.
module srdl_counter_array #(
    parameter int NUM_CH = 4,
    parameter int WIDTH = 32,
    parameter int BUS_WIDTH = 16,
    parameter int INCRWIDTH = 4,
    parameter int DECRWIDTH = 4,
    parameter bit SATURATE = 1'b1,
    parameter logic [WIDTH-1:0] RESET = '0,
    localparam int NW = WIDTH / BUS_WIDTH,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int WORD_W = $clog2(NW + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           incr,
    input  logic [NUM_CH*INCRWIDTH-1:0] incrvalue,
    input  logic [NUM_CH-1:0]           decr,
    input  logic [NUM_CH*DECRWIDTH-1:0] decrvalue,
    input  logic [NUM_CH*WIDTH-1:0]     threshold,
    input  logic [CH_W-1:0]             sw_ch,
    input  logic [WORD_W-1:0]           sw_word,
    input  logic                        rd,
    input  logic                        wr,
    input  logic [BUS_WIDTH-1:0]        sw_wdata,
    output logic [BUS_WIDTH-1:0]        sw_rdata,
    output logic                        rd_ack,
    output logic [NUM_CH*WIDTH-1:0]     q,
    output logic [NUM_CH-1:0]           overflow,
    output logic [NUM_CH-1:0]           underflow,
    output logic [NUM_CH-1:0]           thresh_hit,
    output logic                        intr
);

    logic [WIDTH-1:0]     cnt        [NUM_CH];
    logic [WIDTH-1:0]     cnt_next   [NUM_CH];
    logic [WIDTH+1:0]     sum        [NUM_CH];
    logic [NUM_CH-1:0]    ovf_event;
    logic [NUM_CH-1:0]    udf_event;
    logic [NUM_CH-1:0]    ovf_sticky;
    logic [NUM_CH-1:0]    udf_sticky;
    logic [NUM_CH-1:0]    ovf_clear;
    logic [NUM_CH-1:0]    udf_clear;
    logic [NUM_CH-1:0]    commit;
    logic [WIDTH-1:0]     staging;
    logic [WIDTH-1:0]     commit_val;
    logic [WIDTH-1:0]     sel_cnt;
    logic [BUS_WIDTH-1:0] rdata_next;
    logic                 ch_ok;
    logic                 data_word;
    logic                 status_word;
`ifdef SRDL_CNT_SNAPSHOT_EN
    logic [WIDTH-1:0]     snapshot;
`endif

    assign ch_ok       = int'(sw_ch) < NUM_CH;
    assign data_word   = int'(sw_word) < NW;
    assign status_word = int'(sw_word) == NW;
    assign sel_cnt     = ch_ok ? cnt[sw_ch] : '0;

    always_comb begin
        commit_val = staging;
        commit_val[BUS_WIDTH-1:0] = sw_wdata;
    end

    // The sum carries two extra bits: bit WIDTH flags overflow, bit WIDTH+1 (sign) flags underflow.
    always_comb begin
        ovf_event = '0;
        udf_event = '0;
        commit    = '0;
        ovf_clear = '0;
        udf_clear = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            q[c*WIDTH +: WIDTH] = cnt[c];
            thresh_hit[c]       = cnt[c] >= threshold[c*WIDTH +: WIDTH];
            sum[c] = {2'b00, cnt[c]}
                   + (incr[c] ? (WIDTH+2)'(incrvalue[c*INCRWIDTH +: INCRWIDTH]) : '0)
                   - (decr[c] ? (WIDTH+2)'(decrvalue[c*DECRWIDTH +: DECRWIDTH]) : '0);
            commit[c]    = wr && ch_ok && (sw_ch == CH_W'(c)) && (sw_word == '0);
            ovf_clear[c] = wr && ch_ok && (sw_ch == CH_W'(c)) && status_word && sw_wdata[0];
            udf_clear[c] = wr && ch_ok && (sw_ch == CH_W'(c)) && status_word && sw_wdata[1];
            cnt_next[c]  = sum[c][WIDTH-1:0];
            if (commit[c]) begin
                cnt_next[c] = commit_val;
            end else if (sum[c][WIDTH+1]) begin
                udf_event[c] = 1'b1;
                if (SATURATE) cnt_next[c] = '0;
            end else if (sum[c][WIDTH]) begin
                ovf_event[c] = 1'b1;
                if (SATURATE) cnt_next[c] = '1;
            end
        end
    end

    always_comb begin
        rdata_next = '0;
        if (ch_ok) begin
            if (status_word) begin
                rdata_next[0] = ovf_sticky[sw_ch];
                rdata_next[1] = udf_sticky[sw_ch];
                rdata_next[2] = thresh_hit[sw_ch];
            end else if (data_word) begin
`ifdef SRDL_CNT_SNAPSHOT_EN
                if (sw_word == '0) begin
                    rdata_next = sel_cnt[BUS_WIDTH-1:0];
                end else begin
                    rdata_next = snapshot[int'(sw_word)*BUS_WIDTH +: BUS_WIDTH];
                end
`else
                rdata_next = sel_cnt[int'(sw_word)*BUS_WIDTH +: BUS_WIDTH];
`endif
            end
        end
    end

    // A status set and a W1C in the same cycle leave the sticky bit set.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt[c] <= RESET;
            end
            ovf_sticky <= '0;
            udf_sticky <= '0;
            overflow   <= '0;
            underflow  <= '0;
            staging    <= '0;
            sw_rdata   <= '0;
            rd_ack     <= 1'b0;
            intr       <= 1'b0;
`ifdef SRDL_CNT_SNAPSHOT_EN
            snapshot   <= '0;
`endif
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt[c] <= cnt_next[c];
            end
            ovf_sticky <= (ovf_sticky & ~ovf_clear) | ovf_event;
            udf_sticky <= (udf_sticky & ~udf_clear) | udf_event;
            overflow   <= ovf_event;
            underflow  <= udf_event;
            intr       <= (|ovf_sticky) | (|udf_sticky) | (|thresh_hit);
            rd_ack     <= rd;
            if (rd) begin
                sw_rdata <= rdata_next;
            end
            if (wr && ch_ok && data_word && (sw_word != '0)) begin
                staging[int'(sw_word)*BUS_WIDTH +: BUS_WIDTH] <= sw_wdata;
            end
`ifdef SRDL_CNT_SNAPSHOT_EN
            if (rd && ch_ok && (sw_word == '0)) begin
                snapshot <= sel_cnt;
            end
`endif
        end
    end

endmodule

// File: doc/srdl_counter_array.md
Name: srdl_counter_array

Overview:
- NUM_CH independent hardware event counters behind one software register window.
- Each counter is WIDTH bits wide and is read or written through a narrower BUS_WIDTH data path, one word at a time.
- Each channel has saturating or wrapping increment/decrement, sticky overflow/underflow status, and a threshold compare.
- The per-channel flags are aggregated into one interrupt.
- Sits alongside srdl register fields in generated register blocks for performance/statistics counters.

Parameters:
- NUM_CH, 4, number of counter channels (>=1)
- WIDTH, 32, counter width; must be a multiple of BUS_WIDTH
- BUS_WIDTH, 16, software data width
- INCRWIDTH, 4, per-channel increment amount width
- DECRWIDTH, 4, per-channel decrement amount width
- SATURATE, 1, 1 = clamp at 0 / all-ones; 0 = wrap
- RESET, 0, counter reset value (all channels)

Ports:
- clk, input, 1, clock
- rst, input, 1, synchronous active-high reset
- incr, input, NUM_CH, per-channel increment strobe
- incrvalue, input, NUM_CH*INCRWIDTH, per-channel increment amount; channel c is at [c*INCRWIDTH +: INCRWIDTH]
- decr, input, NUM_CH, per-channel decrement strobe
- decrvalue, input, NUM_CH*DECRWIDTH, per-channel decrement amount
- threshold, input, NUM_CH*WIDTH, per-channel threshold
- sw_ch, input, max(1,$clog2(NUM_CH)), channel select
- sw_word, input, $clog2(WIDTH/BUS_WIDTH+1), word select; index NW = WIDTH/BUS_WIDTH selects the status word
- rd, input, 1, software read strobe
- wr, input, 1, software write strobe
- sw_wdata, input, BUS_WIDTH, write data
- sw_rdata, output, BUS_WIDTH, read data
- rd_ack, output, 1, read data valid
- q, output, NUM_CH*WIDTH, live counter values
- overflow, output, NUM_CH, single-cycle overflow pulse
- underflow, output, NUM_CH, single-cycle underflow pulse
- thresh_hit, output, NUM_CH, asserted when q[c] >= threshold[c] (combinational from q)
- intr, output, 1, registered OR of all sticky flags and thresh_hit

Behaviour:
- Reset:
  - q = RESET on every channel.
  - Sticky flags, snapshot, staging, sw_rdata, rd_ack, overflow, underflow and intr all clear to 0.
  - Reset mid-access discards any pending staging or snapshot.
- Hardware update, per channel, each cycle:
  - sum = q + (incr ? incrvalue : 0) - (decr ? decrvalue : 0), evaluated in WIDTH+2 signed bits.
  - sum > 2^WIDTH-1: overflow pulses next cycle; q becomes all-ones if SATURATE, else sum mod 2^WIDTH.
  - sum < 0: underflow pulses next cycle; q becomes 0 if SATURATE, else sum mod 2^WIDTH.
  - incr and decr together: only the net result matters, so +3 -3 gives no change and no flag.
- Software write, word w < NW, channel c:
  - w != 0: sw_wdata goes into a per-block staging register at slice w. q is unchanged.
  - w == 0: q[c] = {staging[upper], sw_wdata}, committed atomically. That cycle's hardware events for channel c are dropped, and no overflow/underflow is raised.
  - The staging register is shared by all channels and keeps its value after a commit.
- Software write, status word (w == NW):
  - bit0 = ovf sticky, bit1 = udf sticky; write-1-to-clear.
  - A set on the same cycle as a clear wins.
- Software read:
  - sw_rdata and rd_ack are registered, giving 1-cycle latency. rd_ack is a 1-cycle pulse.
  - Word 0 returns q[c] bits [BUS_WIDTH-1:0] from the pre-update value and loads the snapshot with the full q[c].
  - Words 1..NW-1 return the snapshot slice.
  - Status word returns {zeros, thresh_hit[c], udf_sticky, ovf_sticky}.
  - Out-of-range sw_ch or sw_word reads 0, writes are ignored, and rd_ack still pulses.
- rd and wr together: the write takes effect and the read returns the pre-write value.
- intr is registered: it rises 1 cycle after a sticky flag sets or thresh_hit asserts, and falls 1 cycle after all of them clear.

Optional Feature:
- Macro: SRDL_CNT_SNAPSHOT_EN
- Defined: read-snapshot behaviour as described above, giving a coherent multi-word read.
- Undefined: no snapshot register. Every word read returns the live q[c] slice, and word 0 reads have no side effect.

Test Plan:
- Reset, WIDTH=32, BUS_WIDTH=16, SATURATE=1 -> q=0 on all channels, intr=0; rd ch0 word0 -> rd_ack after 1 cycle, sw_rdata=0x0000.
- Set ch1 q=0xFFFFFFFE, incr with incrvalue=5 -> q=0xFFFFFFFF, overflow[1] pulses 1 cycle, status bit0=1, intr=1; write status 0x1 -> sticky clears, intr drops next cycle.
- SATURATE=0, ch2 q=0x00000001, decr with decrvalue=3 -> q=0xFFFFFFFE, underflow[2] pulses.
- Snapshot coherence: ch0 q=0x0001FFFF, read word0 (0xFFFF), then incr by 1, then read word1 -> 0x0001 with macro defined, 0x0002 without.
- Staged write: write word1=0xABCD, then word0=0x1234 on ch3 while incr[3]=1 -> q[3]=0xABCD1234 exactly, no increment applied.
- Threshold: threshold[0]=10, increment ch0 from 9 by 1 -> thresh_hit[0]=1 and intr=1 next cycle; simultaneous status W1C and new overflow -> sticky stays 1.
